ucode_sequencer: RTL
====================

Name: ucode_sequencer

Overview:
- Instruction-level sequencer for the CPU core.
- Fetches opcode bytes over the memory handshake and presents the latched opcode to the microcode lookup.
- Steps each instruction through its multi-cycle execute phase, stalling on memory, and gates the datapath control word.
- Handles HALT and maskable-interrupt entry at instruction boundaries; sits between the bus interface, the microcode lookup and the register/ALU datapath.

Parameters:
- CTRL_W, 60, width of the microcode control word.
- STEP_W, 3, width of the execute step counter (max 8 steps per instruction).
- IRQ_OPCODE, 8'hFF, opcode injected on interrupt entry; its microcode pushes PC and loads the vector.
- HALT_OPCODE, 8'h76, opcode that enters HALT.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory access request; held until mem_ack.
- mem_we  out  1  1 = write; valid while mem_req.
- mem_fetch  out  1  1 = access is an opcode fetch at PC.
- mem_ack  in  1  access complete; read data valid this cycle.
- mem_rdata  in  8  read data.
- opcode_out  out  8  opcode to the microcode lookup.
- ctrl_in  in  CTRL_W  control word returned for opcode_out (combinational lookup).
- ctrl_out  out  CTRL_W-6  datapath control bits ctrl_in[53:0]; forced to 0 outside EXEC.
- ctrl_valid  out  1  ctrl_out is live this cycle.
- step  out  STEP_W  current execute step, for datapath muxing.
- pc_inc  out  1  one-cycle pulse: increment PC.
- ime  in  1  interrupt master enable from the datapath.
- irq_req  in  1  pending enabled interrupt.
- irq_vec  in  3  index of the highest-priority pending interrupt.
- irq_ack  out  1  one-cycle pulse: interrupt taken.
- vec_override  out  1  vector addr valid for the injected IRQ_OPCODE.
- vec_addr  out  16  16'h0040 + {irq_vec_latched, 3'b000}.
- halted  out  1  core in HALT.

Behaviour:
- ctrl_in fields:
  - [59:57] last_step, the index of the final execute step.
  - [56] mem_op, meaning the step needs a memory access.
  - [55] mem_wr.
  - [54] reserved.
  - [53:0] datapath enables.
- States: FETCH, EXEC, MEM_WAIT, HALT, IRQ.
- Reset (async on reset_n low): state=FETCH, all outputs 0, opcode register=8'h00, step=0, irq_vec_latched=0.
- mem_req is registered: it first rises on the first clk edge after reset_n deasserts.
- FETCH:
  - mem_req=1, mem_fetch=1, mem_we=0.
  - On mem_ack: latch mem_rdata into the opcode register, pulse pc_inc, set step=0, go to EXEC.
  - If the latched byte == HALT_OPCODE, go to HALT instead, with no EXEC cycle.
- EXEC:
  - opcode_out=opcode register, ctrl_valid=1, ctrl_out=ctrl_in[53:0].
  - If mem_op=1: assert mem_req and mem_we=mem_wr in the same cycle.
    - With mem_ack in that same cycle, there is no stall.
    - Without it, go to MEM_WAIT, holding step and ctrl_out.
  - If the step completes and step < last_step: step+1 and stay in EXEC.
  - If the step completes and step == last_step (instruction boundary):
    - if ime && irq_req, go to IRQ;
    - otherwise go to FETCH.
- MEM_WAIT:
  - ctrl_valid=0, but mem_req/mem_we are held.
  - On mem_ack: ctrl_valid=1 for exactly one cycle (commit), then advance exactly as in EXEC.
- HALT:
  - halted=1, no memory requests.
  - On irq_req=1 (regardless of ime): if ime, go to IRQ; otherwise go to FETCH. halted drops on exit.
- IRQ (one cycle):
  - pulse irq_ack, latch irq_vec, load the opcode register with IRQ_OPCODE, step=0, go to EXEC.
  - vec_override=1 for the whole injected instruction; no pc_inc.
- Minimum instruction latency: 1 fetch cycle + (last_step+1) execute cycles, with zero wait states.
- step never wraps: last_step ≤ 2^STEP_W−1 by construction.
- irq_req is sampled only at boundaries; a mid-instruction request is deferred, never lost, while irq_req stays high.
- Reset mid-MEM_WAIT: mem_req drops asynchronously; the bus is expected to abandon the access.

Decomposition:
- Shared package holds:
  - ctrl field index constants (LAST_STEP_HI/LO, MEM_OP_BIT, MEM_WR_BIT, DP_CTRL_HI).
  - the state enumeration.
  - HALT/IRQ opcode constants and IRQ_VECTOR_BASE=16'h0040.
- No sub-module needed. The optional small irq_entry unit (vector compute + latch) is kept inline.

Test Plan:
- Reset release with mem_ack tied 1 and mem_rdata=8'h00 (last_step=0) -> mem_req rises the first cycle after reset; instructions alternate FETCH/EXEC, with pc_inc once per 2 cycles.
- 3-step opcode, no mem_op, mem_ack tied 1 -> step goes 0,1,2 with ctrl_valid=1 each cycle, then FETCH; 4 cycles per instruction.
- Step 1 has mem_op=1, mem_wr=1, and mem_ack delayed 3 cycles -> mem_req/mem_we held 4 cycles, ctrl_valid=0 during the wait, step stays 1, commit pulse on ack.
- irq_req=1, irq_vec=3, ime=1, raised mid-instruction -> no effect until the boundary; then irq_ack one pulse, opcode_out=8'hFF, vec_addr=16'h0058, no pc_inc.
- Fetch 8'h76 -> halted=1 and no mem_req.
  - With ime=0 and irq_req=1: halted drops and FETCH resumes, no irq_ack.
  - With ime=1: irq_ack is pulsed.
- Drop reset_n during MEM_WAIT -> all outputs 0 immediately; fetch restarts after release.

Source files
------------

// File: rtl/ucode_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: microcode control-word
// field positions, sequencer states and the fixed HALT/IRQ constants.
package ucode_sequencer_pkg;

  // Microcode control-word field positions
  localparam int LAST_STEP_HI = 59;
  localparam int LAST_STEP_LO = 57;
  localparam int MEM_OP_BIT   = 56;
  localparam int MEM_WR_BIT   = 55;
  localparam int RSVD_BIT     = 54;
  localparam int DP_CTRL_HI   = 53;

  localparam logic [7:0]  HALT_OPCODE_DEF = 8'h76;
  localparam logic [7:0]  IRQ_OPCODE_DEF  = 8'hFF;
  localparam logic [15:0] IRQ_VECTOR_BASE = 16'h0040;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_EXEC     = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_HALT     = 3'd3,
    ST_IRQ      = 3'd4
  } seq_state_e;

  // Interrupt vectors are spaced 8 bytes apart above the vector base.
  function automatic logic [15:0] vector_addr(input logic [2:0] vec);
    return IRQ_VECTOR_BASE + {10'd0, vec, 3'b000};
  endfunction

endpackage

// File: rtl/ucode_sequencer.sv
// Instruction-level sequencer: opcode fetch, multi-cycle execute with memory
// stalls, HALT and interrupt entry at instruction boundaries.
module ucode_sequencer
  import ucode_sequencer_pkg::*;
#(
  parameter int         CTRL_W      = 60,
  parameter int         STEP_W      = 3,
  parameter logic [7:0] IRQ_OPCODE  = IRQ_OPCODE_DEF,
  parameter logic [7:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_fetch,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        opcode_out,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [CTRL_W-7:0] ctrl_out,
  output logic              ctrl_valid,
  output logic [STEP_W-1:0] step,
  output logic              pc_inc,
  input  logic              ime,
  input  logic              irq_req,
  input  logic [2:0]        irq_vec,
  output logic              irq_ack,
  output logic              vec_override,
  output logic [15:0]       vec_addr,
  output logic              halted
);

  seq_state_e        state_q, state_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [2:0]        irq_vec_q, irq_vec_d;
  logic              vec_q, vec_d;
  logic              fetch_req_q, fetch_req_d;

  logic [STEP_W-1:0] last_step;
  logic              mem_op;
  logic              mem_wr;
  logic              advance;
  logic              exec_phase;
  logic              rsvd_unused;

  assign last_step   = STEP_W'(ctrl_in[LAST_STEP_HI:LAST_STEP_LO]);
  assign mem_op      = ctrl_in[MEM_OP_BIT];
  assign mem_wr      = ctrl_in[MEM_WR_BIT];
  assign rsvd_unused = ctrl_in[RSVD_BIT];

  always_comb begin
    // NOTE: every combinational output and next-state value gets a default
    // here first, so no path through the case below can infer a latch.
    state_d     = state_q;
    opcode_d    = opcode_q;
    step_d      = step_q;
    irq_vec_d   = irq_vec_q;
    vec_d       = vec_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_fetch   = 1'b0;
    ctrl_valid  = 1'b0;
    pc_inc      = 1'b0;
    irq_ack     = 1'b0;
    advance     = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        // The fetch request is qualified by a register so it stays low
        // until the first clock edge after reset is released.
        mem_req   = fetch_req_q;
        mem_fetch = fetch_req_q;
        if (fetch_req_q && mem_ack) begin
          opcode_d = mem_rdata;
          pc_inc   = 1'b1;
          step_d   = '0;
          state_d  = (mem_rdata == HALT_OPCODE) ? ST_HALT : ST_EXEC;
        end
      end

      ST_EXEC: begin
        ctrl_valid = 1'b1;
        if (mem_op) begin
          mem_req = 1'b1;
          mem_we  = mem_wr;
        end
        if (!mem_op || mem_ack) begin
          advance = 1'b1;
        end else begin
          state_d = ST_MEM_WAIT;
        end
      end

      ST_MEM_WAIT: begin
        mem_req = 1'b1;
        mem_we  = mem_wr;
        if (mem_ack) begin
          ctrl_valid = 1'b1;
          advance    = 1'b1;
        end
      end

      ST_HALT: begin
        if (irq_req) begin
          state_d = ime ? ST_IRQ : ST_FETCH;
        end
      end

      ST_IRQ: begin
        irq_ack   = 1'b1;
        irq_vec_d = irq_vec;
        opcode_d  = IRQ_OPCODE;
        step_d    = '0;
        vec_d     = 1'b1;
        state_d   = ST_EXEC;
      end

      default: state_d = ST_FETCH;
    endcase

    // Step completion: either move to the next step or reach the boundary,
    // the only place an interrupt is allowed in.
    if (advance) begin
      if (step_q < last_step) begin
        step_d  = step_q + STEP_W'(1);
        state_d = ST_EXEC;
      end else begin
        vec_d   = 1'b0;
        state_d = (ime && irq_req) ? ST_IRQ : ST_FETCH;
      end
    end

    fetch_req_d = (state_d == ST_FETCH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FETCH;
      opcode_q    <= 8'h00;
      step_q      <= '0;
      irq_vec_q   <= 3'd0;
      vec_q       <= 1'b0;
      fetch_req_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge value of its neighbours.
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      step_q      <= step_d;
      irq_vec_q   <= irq_vec_d;
      vec_q       <= vec_d;
      fetch_req_q <= fetch_req_d;
    end
  end

  // The control word stays on the datapath while a memory step is stalled;
  // ctrl_valid alone says when it may commit.
  assign exec_phase   = (state_q == ST_EXEC) || (state_q == ST_MEM_WAIT);
  assign ctrl_out     = exec_phase ? ctrl_in[DP_CTRL_HI:0] : '0;
  assign opcode_out   = opcode_q;
  assign step         = step_q;
  assign vec_override = vec_q;
  assign vec_addr     = vec_q ? vector_addr(irq_vec_q) : 16'h0000;
  assign halted       = (state_q == ST_HALT);

endmodule
